// File: rtl/serial_in_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, rxready status.
// Define SERIAL_IN_OVERRUN_EN to add the sticky overrun output.
module serial_in_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       m_clock,
  input  logic       p_reset,
  input  logic       rxd,
  input  logic       port_read,
  output logic [7:0] data,
  output logic       rxready,
`ifdef SERIAL_IN_OVERRUN_EN
  output logic       overrun,
`endif
  output logic       done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  logic          r_sync;
  logic          r_rxs;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_rxready;
  logic          r_done;

  state_t        w_state_nx;
  logic [CW-1:0] w_cnt_nx;
  logic [2:0]    w_bit_nx;
  logic [7:0]    w_shift_nx;
  logic          w_accept;
  logic          w_expired;
  logic          w_rxready_nx;

  assign w_expired = (r_cnt == '0);

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      r_sync <= 1'b1;
      r_rxs  <= 1'b1;
    end else begin
      r_sync <= rxd;
      r_rxs  <= r_sync;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_accept   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!r_rxs) begin
          w_cnt_nx   = HALF;
          w_state_nx = S_START;
        end
      end
      S_START: begin
        if (!w_expired) begin
          w_cnt_nx = r_cnt - 1'b1;
        end else if (r_rxs) begin
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_nx   = FULL;
          w_bit_nx   = 3'd0;
          w_state_nx = S_DATA;
        end
      end
      S_DATA: begin
        if (!w_expired) begin
          w_cnt_nx = r_cnt - 1'b1;
        end else begin
          w_shift_nx = {r_rxs, r_shift[7:1]};
          w_cnt_nx   = FULL;
          w_bit_nx   = r_bit + 1'b1;
          if (r_bit == 3'd7) w_state_nx = S_STOP;
        end
      end
      S_STOP: begin
        if (!w_expired) begin
          w_cnt_nx = r_cnt - 1'b1;
        end else if (r_rxs) begin
          w_accept   = 1'b1;
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        if (r_rxs) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // A read landing in the done cycle collides with the accept; accept wins.
  always_comb begin
    w_rxready_nx = r_rxready;
    if (w_accept) begin
      w_rxready_nx = 1'b1;
    end else if (port_read && !r_done) begin
      w_rxready_nx = 1'b0;
    end
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= 3'd0;
      r_shift   <= 8'h00;
      r_data    <= 8'h00;
      r_rxready <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_bit     <= w_bit_nx;
      r_shift   <= w_shift_nx;
      r_rxready <= w_rxready_nx;
      r_done    <= w_accept;
      if (w_accept) r_data <= r_shift;
    end
  end

`ifdef SERIAL_IN_OVERRUN_EN
  logic r_ovr_pend;
  logic r_overrun;

  // Decided in the done cycle so a colliding read suppresses the set.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      r_ovr_pend <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_ovr_pend <= w_accept && r_rxready && !port_read;
      if (r_done && r_ovr_pend && !port_read) begin
        r_overrun <= 1'b1;
      end else if (port_read) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign overrun = r_overrun;
`endif

  assign data    = r_data;
  assign rxready = r_rxready;
  assign done    = r_done;

endmodule

// File: tb/tb_serial_in_rx.sv
// Directed bench for serial_in_rx at 16 clocks per bit.
`timescale 1ns/1ps
module tb_serial_in_rx;

  localparam int N = 16;

  logic       m_clock = 1'b0;
  logic       p_reset;
  logic       rxd;
  logic       port_read;
  logic [7:0] data;
  logic       rxready;
  logic       done;
`ifdef SERIAL_IN_OVERRUN_EN
  logic       overrun;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_done = 0;
  int t_done = 0;
  int t_fall = 0;

  serial_in_rx #(.CLKS_PER_BIT(N)) dut (
    .m_clock  (m_clock),
    .p_reset  (p_reset),
    .rxd      (rxd),
    .port_read(port_read),
    .data     (data),
    .rxready  (rxready),
`ifdef SERIAL_IN_OVERRUN_EN
    .overrun  (overrun),
`endif
    .done     (done)
  );

  always #5 m_clock = ~m_clock;

  always @(posedge m_clock) cyc <= cyc + 1;

  always @(negedge m_clock) begin
    if (done) begin
      n_done <= n_done + 1;
      t_done <= cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge m_clock);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    t_fall = cyc;
    tick(N);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(N);
    end
    rxd = stop_bit;
    tick(N);
    rxd = 1'b1;
  endtask

  task automatic read_pulse();
    port_read = 1'b1;
    tick(1);
    port_read = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (data !== 8'h00) begin
      bad++; $display("FAIL reset_data got=%h want=00", data);
    end
    total++;
    if (rxready !== 1'b0) begin
      bad++; $display("FAIL reset_rxready got=%b want=0", rxready);
    end
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL reset_done got=%b want=0", done);
    end
`ifdef SERIAL_IN_OVERRUN_EN
    total++;
    if (overrun !== 1'b0) begin
      bad++; $display("FAIL reset_overrun got=%b want=0", overrun);
    end
`endif
  endtask

  task automatic test_single();
    int n0;
    int lat;
    n0 = n_done;
    send_frame(8'h41, 1'b1);
    tick(4);
    lat = t_done - t_fall;
    total++;
    if (n_done - n0 !== 1) begin
      bad++; $display("FAIL single_pulses got=%0d want=1", n_done - n0);
    end
    total++;
    if (lat < 153 || lat > 155) begin
      bad++; $display("FAIL single_latency got=%0d want=153..155", lat);
    end
    total++;
    if (data !== 8'h41) begin
      bad++; $display("FAIL single_data got=%h want=41", data);
    end
    total++;
    if (rxready !== 1'b1) begin
      bad++; $display("FAIL single_rxready got=%b want=1", rxready);
    end
    read_pulse();
    total++;
    if (rxready !== 1'b0) begin
      bad++; $display("FAIL read_clear got=%b want=0", rxready);
    end
    total++;
    if (data !== 8'h41) begin
      bad++; $display("FAIL read_data got=%h want=41", data);
    end
  endtask

  task automatic test_glitch();
    int n0;
    n0 = n_done;
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(40);
    total++;
    if (n_done !== n0) begin
      bad++; $display("FAIL glitch_done got=%0d want=%0d", n_done, n0);
    end
    send_frame(8'h55, 1'b1);
    tick(4);
    total++;
    if (data !== 8'h55 || n_done - n0 !== 1) begin
      bad++;
      $display("FAIL glitch_next got=%h/%0d want=55/1", data, n_done - n0);
    end
  endtask

  task automatic test_framing();
    int n0;
    n0 = n_done;
    send_frame(8'hA5, 1'b0);
    rxd = 1'b0;
    tick(40);
    rxd = 1'b1;
    tick(20);
    total++;
    if (n_done !== n0) begin
      bad++; $display("FAIL frame_done got=%0d want=%0d", n_done, n0);
    end
    total++;
    if (data !== 8'h55) begin
      bad++; $display("FAIL frame_data got=%h want=55", data);
    end
    total++;
    if (rxready !== 1'b1) begin
      bad++; $display("FAIL frame_rxready got=%b want=1", rxready);
    end
    send_frame(8'h3C, 1'b1);
    tick(4);
    total++;
    if (data !== 8'h3C) begin
      bad++; $display("FAIL frame_next got=%h want=3C", data);
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    read_pulse();
    tick(2);
    n0 = n_done;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick(4);
    total++;
    if (n_done - n0 !== 2) begin
      bad++; $display("FAIL b2b_pulses got=%0d want=2", n_done - n0);
    end
    total++;
    if (data !== 8'hFF) begin
      bad++; $display("FAIL b2b_data got=%h want=FF", data);
    end
    total++;
    if (rxready !== 1'b1) begin
      bad++; $display("FAIL b2b_rxready got=%b want=1", rxready);
    end
`ifdef SERIAL_IN_OVERRUN_EN
    total++;
    if (overrun !== 1'b1) begin
      bad++; $display("FAIL b2b_overrun got=%b want=1", overrun);
    end
`endif
    read_pulse();
    total++;
    if (rxready !== 1'b0) begin
      bad++; $display("FAIL b2b_read got=%b want=0", rxready);
    end
`ifdef SERIAL_IN_OVERRUN_EN
    total++;
    if (overrun !== 1'b0) begin
      bad++; $display("FAIL b2b_ovr_clear got=%b want=0", overrun);
    end
`endif
  endtask

  task automatic test_collision();
    bit seen;
    send_frame(8'h12, 1'b1);
    tick(4);
    seen = 1'b0;
    fork
      send_frame(8'h34, 1'b1);
      begin
        for (int i = 0; i < 20 * N && !seen; i++) begin
          @(negedge m_clock);
          if (done) seen = 1'b1;
        end
        if (seen) begin
          port_read = 1'b1;
          @(posedge m_clock);
          #1;
          port_read = 1'b0;
        end
      end
    join
    tick(4);
    total++;
    if (!seen) begin
      bad++; $display("FAIL coll_timeout got=0 want=1");
    end
    total++;
    if (rxready !== 1'b1) begin
      bad++; $display("FAIL coll_rxready got=%b want=1", rxready);
    end
    total++;
    if (data !== 8'h34) begin
      bad++; $display("FAIL coll_data got=%h want=34", data);
    end
`ifdef SERIAL_IN_OVERRUN_EN
    total++;
    if (overrun !== 1'b0) begin
      bad++; $display("FAIL coll_overrun got=%b want=0", overrun);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    int n0;
    b = 8'h77;
    rxd = 1'b0;
    tick(N);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      tick(N);
    end
    #2;
    p_reset = 1'b0;
    rxd = 1'b1;
    #1;
    test_reset();
    tick(3);
    p_reset = 1'b1;
    tick(20);
    n0 = n_done;
    send_frame(8'h99, 1'b1);
    tick(4);
    total++;
    if (data !== 8'h99 || rxready !== 1'b1 || n_done - n0 !== 1) begin
      bad++;
      $display("FAIL rst_next got=%h/%b/%0d want=99/1/1",
               data, rxready, n_done - n0);
    end
  endtask

  initial begin
    p_reset = 1'b0;
    rxd = 1'b1;
    port_read = 1'b0;
    tick(3);
    test_reset();
    p_reset = 1'b1;
    tick(10);
    test_single();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_collision();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
